download_loader: RTL and testbench

Parametrised successor to the single-purpose Laser 500 downloader. Sits between the data_io SPI receiver and the SDRAM write port. Maps each download index to a RAM region and buffers bytes in a small FIFO behind a wr/ack handshake. After a PRG load it patches PTR_COUNT little-endian BASIC pointers with the program end address, expressed in CPU address space.

---
 rtl/download_loader_if.sv | 25 ++
 rtl/download_loader.sv | 181 ++++++++++++++++++
 tb/tb_download_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/download_loader_if.sv
// Download-side bus of the loader: data_io byte stream in, RAM write handshake out.
// The loader connects through the slave modport, the surrounding system through master.
interface download_loader_if #(
    parameter int ADDR_W = 25
);
    logic              dio_downloading;
    logic [4:0]        dio_index;
    logic              dio_wr;
    logic [ADDR_W-1:0] dio_addr;
    logic [7:0]        dio_data;
    logic              ram_ack;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;

    modport slave (
        input  dio_downloading, dio_index, dio_wr, dio_addr, dio_data, ram_ack,
        output wr, addr, data
    );

    modport master (
        output dio_downloading, dio_index, dio_wr, dio_addr, dio_data, ram_ack,
        input  wr, addr, data
    );
endinterface

// File: rtl/download_loader.sv
// Maps data_io downloads into RAM regions through a small write FIFO and, after a
// PRG load, patches BASIC end-of-program pointers with the CPU-space end address.
module download_loader #(
    parameter int                ADDR_W       = 25,
    parameter int                FIFO_DEPTH   = 4,
    parameter logic [4:0]        ROM_INDEX    = 5'd0,
    parameter logic [4:0]        PRG_INDEX    = 5'd1,
    parameter logic [ADDR_W-1:0] ROM_BASE     = 25'h0,
    parameter logic [ADDR_W-1:0] PRG_BASE     = 25'h10995,
    parameter logic [15:0]       PRG_CPU_BASE = 16'h8995,
    parameter logic [ADDR_W-1:0] PTR_ADDR     = 25'h103E9,
    parameter int                PTR_BYTES    = 2,
    parameter int                PTR_COUNT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    download_loader_if.slave    bus,
    output logic                downloading,
    output logic                overflow
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int PTR_TOTAL = PTR_COUNT * PTR_BYTES;
    localparam int PIDX_W    = $clog2(PTR_TOTAL + 1);
    localparam int PB_W      = (PTR_BYTES > 1) ? $clog2(PTR_BYTES) : 1;
    localparam int VAL_W     = 8 * PTR_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_DRAIN, ST_PATCH, ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [4:0]        r_index;
    logic [15:0]       r_length;
    logic              r_downloading;
    logic              r_overflow;
    logic              r_dio_wr_d;
    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [7:0]        r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic [PIDX_W-1:0] r_patch_idx;
    logic [PB_W-1:0]   r_patch_b;

    logic              w_wr_rise;
    logic              w_push_try;
    logic              w_full;
    logic              w_push;
    logic              w_ack;
    logic              w_pop;
    logic              w_load_fifo;
    logic              w_load_patch;
    logic [PTR_W-1:0]  w_load_ptr;
    logic [ADDR_W-1:0] w_map_addr;
    logic [VAL_W-1:0]  w_value;
    logic [7:0]        w_patch_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_rise    = bus.dio_wr & ~r_dio_wr_d;
        w_push_try   = (r_state == ST_LOAD) && w_wr_rise;
        w_full       = (r_count == CNT_W'(FIFO_DEPTH));
        w_push       = w_push_try && !w_full;
        w_ack        = r_wr && bus.ram_ack;
        // Pointer writes never come from the FIFO, so their acks must not pop it.
        w_pop        = w_ack && (r_state != ST_PATCH);
        // The presented entry stays in the FIFO until acked; reload from the next slot.
        w_load_fifo  = (!r_wr && (r_count != '0)) || (w_ack && (r_count > CNT_W'(1)));
        w_load_ptr   = r_wr ? (r_rptr + PTR_W'(1)) : r_rptr;
        w_load_patch = (r_state == ST_PATCH) && !r_wr && (r_patch_idx < PIDX_W'(PTR_TOTAL));
        w_value      = VAL_W'(PRG_CPU_BASE) + VAL_W'(r_length);
        w_patch_byte = w_value[{r_patch_b, 3'b000} +: 8];

        if (r_index == ROM_INDEX) begin
            w_map_addr = ROM_BASE + bus.dio_addr;
        end else if (r_index == PRG_INDEX) begin
            w_map_addr = PRG_BASE + bus.dio_addr;
        end else begin
            w_map_addr = bus.dio_addr;
        end

        case (r_state)
            ST_IDLE:  if (bus.dio_downloading) w_state_next = ST_LOAD;
            ST_LOAD:  if (!bus.dio_downloading) w_state_next = ST_DRAIN;
            ST_DRAIN: if ((r_count == '0) && !r_wr)
                          w_state_next = (r_index == PRG_INDEX) ? ST_PATCH : ST_DONE;
            ST_PATCH: if (w_ack && (r_patch_idx == PIDX_W'(PTR_TOTAL - 1)))
                          w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= w_map_addr;
            r_fifo_data[r_wptr] <= bus.dio_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_index       <= '0;
            r_length      <= '0;
            r_downloading <= 1'b0;
            r_overflow    <= 1'b0;
            r_dio_wr_d    <= 1'b0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_patch_idx   <= '0;
            r_patch_b     <= '0;
        end else begin
            r_dio_wr_d <= bus.dio_wr;

            if ((r_state == ST_IDLE) && bus.dio_downloading) begin
                r_index       <= bus.dio_index;
                r_length      <= '0;
                r_overflow    <= 1'b0;
                r_downloading <= 1'b1;
                r_patch_idx   <= '0;
                r_patch_b     <= '0;
            end

            // Length follows every strobe, including one dropped on overflow.
            if (w_push_try) begin
                r_length <= 16'(bus.dio_addr) + 16'd1;
                if (w_full) r_overflow <= 1'b1;
            end

            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_load_fifo) begin
                r_wr   <= 1'b1;
                r_addr <= r_fifo_addr[w_load_ptr];
                r_data <= r_fifo_data[w_load_ptr];
            end else if (w_load_patch) begin
                r_wr   <= 1'b1;
                r_addr <= PTR_ADDR + ADDR_W'(r_patch_idx);
                r_data <= w_patch_byte;
            end else if (w_ack) begin
                r_wr <= 1'b0;
            end

            if ((r_state == ST_PATCH) && w_ack) begin
                r_patch_idx <= r_patch_idx + PIDX_W'(1);
                r_patch_b   <= (r_patch_b == PB_W'(PTR_BYTES - 1)) ? '0 : r_patch_b + PB_W'(1);
            end

            if (r_state == ST_DONE) r_downloading <= 1'b0;
        end
    end

    assign downloading = r_downloading;
    assign overflow    = r_overflow;
    assign bus.wr      = r_wr;
    assign bus.addr    = r_addr;
    assign bus.data    = r_data;
endmodule

// File: tb/tb_download_loader.sv
// Directed bench for download_loader: expected RAM writes are queued as bytes are sent
// and matched against each acknowledged write; held requests must stay stable.
module tb_download_loader;
    localparam int          ADDR_W       = 25;
    localparam int          FIFO_DEPTH   = 2;
    localparam int          PTR_BYTES    = 2;
    localparam int          PTR_COUNT    = 3;
    localparam logic [24:0] PRG_BASE     = 25'h10995;
    localparam logic [24:0] PTR_ADDR     = 25'h103E9;
    localparam logic [15:0] PRG_CPU_BASE = 16'h8995;

    typedef struct packed {
        logic [24:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic downloading;
    logic overflow;

    wr_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   writes_seen = 0;
    int   ack_mode = 0;
    int   cyc = 0;

    logic        p_wr = 1'b0;
    logic        p_ack = 1'b0;
    logic [24:0] p_addr = '0;
    logic [7:0]  p_data = '0;

    download_loader_if #(.ADDR_W(ADDR_W)) bus ();

    download_loader #(
        .ADDR_W(ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .PTR_BYTES(PTR_BYTES),
        .PTR_COUNT(PTR_COUNT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .downloading(downloading),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // RAM acknowledge pattern: 0 = always, 1 = every 4th cycle, 2 = never
    initial begin
        bus.ram_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ack_mode)
                0:       bus.ram_ack = 1'b1;
                1:       bus.ram_ack = ((cyc % 4) == 0);
                default: bus.ram_ack = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (!reset && p_wr && !p_ack) begin
            checks++;
            assert (bus.wr === 1'b1 && bus.addr === p_addr && bus.data === p_data) else begin
                failures++;
                $error("FAIL hold observed wr=%b addr=%h data=%h expected wr=1 addr=%h data=%h",
                       bus.wr, bus.addr, bus.data, p_addr, p_data);
            end
        end
        if (bus.wr === 1'b1 && bus.ram_ack === 1'b1) begin
            writes_seen++;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_write observed addr=%h data=%h expected no write",
                       bus.addr, bus.data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (bus.addr === e.a && bus.data === e.d) else begin
                    failures++;
                    $error("FAIL write observed addr=%h data=%h expected addr=%h data=%h",
                           bus.addr, bus.data, e.a, e.d);
                end
                $display("write addr=%h data=%h", bus.addr, bus.data);
            end
        end
        p_wr   = bus.wr && !reset;
        p_ack  = bus.ram_ack;
        p_addr = bus.addr;
        p_data = bus.data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input logic [4:0] idx);
        bus.dio_index       = idx;
        bus.dio_downloading = 1'b1;
        tick(1);
        chk("downloading_rise", {31'd0, downloading}, 32'd1);
    endtask

    task automatic strobe(input logic [4:0] idx, input logic [24:0] off, input logic [7:0] d,
                          input int gap, input bit kept);
        wr_t e;
        bus.dio_addr = off;
        bus.dio_data = d;
        bus.dio_wr   = 1'b1;
        if (kept) begin
            e.a = (idx == 5'd1) ? (PRG_BASE + off) : off;
            e.d = d;
            exp_q.push_back(e);
        end
        tick(1);
        bus.dio_wr = 1'b0;
        tick(gap - 1);
    endtask

    task automatic finish_load(input bit is_prg, input logic [15:0] len);
        wr_t         e;
        logic [15:0] v;
        int          n;
        v = PRG_CPU_BASE + len;
        if (is_prg) begin
            for (int k = 0; k < PTR_COUNT; k++) begin
                for (int b = 0; b < PTR_BYTES; b++) begin
                    e.a = PTR_ADDR + 25'(k * PTR_BYTES + b);
                    e.d = (b == 0) ? v[7:0] : v[15:8];
                    exp_q.push_back(e);
                end
            end
        end
        bus.dio_downloading = 1'b0;
        n = 0;
        while (downloading !== 1'b0 && n < 400) begin
            tick(1);
            n++;
        end
        chk("downloading_fall", {31'd0, downloading}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int  ws0;
        int  n;
        wr_t e;
        bus.dio_downloading = 1'b0;
        bus.dio_index       = '0;
        bus.dio_wr          = 1'b0;
        bus.dio_addr        = '0;
        bus.dio_data        = '0;

        tick(3);
        chk("rst_downloading", {31'd0, downloading}, 32'd0);
        chk("rst_wr", {31'd0, bus.wr}, 32'd0);
        chk("rst_addr", {7'd0, bus.addr}, 32'd0);
        chk("rst_data", {24'd0, bus.data}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        tick(2);

        // ROM load, immediate acks
        ack_mode = 0;
        start_load(5'd0);
        strobe(5'd0, 25'd0, 8'hAA, 2, 1'b1);
        strobe(5'd0, 25'd1, 8'hBB, 2, 1'b1);
        strobe(5'd0, 25'd2, 8'hCC, 2, 1'b1);
        finish_load(1'b0, 16'd0);
        chk("rom_overflow", {31'd0, overflow}, 32'd0);
        tick(3);

        // PRG load of 16 bytes, immediate acks: pointer value 'h89A5
        start_load(5'd1);
        for (int i = 0; i < 16; i++) strobe(5'd1, 25'(i), 8'(8'h40 + i), 2, 1'b1);
        finish_load(1'b1, 16'd16);
        tick(3);

        // PRG load of 4 bytes with sparse acks: requests held between acks
        ack_mode = 1;
        start_load(5'd1);
        for (int i = 0; i < 4; i++) strobe(5'd1, 25'(i), 8'(8'h10 + i), 8, 1'b1);
        finish_load(1'b1, 16'd4);
        chk("slow_overflow", {31'd0, overflow}, 32'd0);
        ack_mode = 0;
        tick(3);

        // Overflow: no acks, third byte dropped (same offset keeps length at 2)
        ack_mode = 2;
        start_load(5'd1);
        strobe(5'd1, 25'd0, 8'h11, 2, 1'b1);
        strobe(5'd1, 25'd1, 8'h22, 2, 1'b1);
        strobe(5'd1, 25'd1, 8'h33, 2, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_held_wr", {31'd0, bus.wr}, 32'd1);
        chk("ovf_held_addr", {7'd0, bus.addr}, {7'd0, PRG_BASE});
        ack_mode = 0;
        finish_load(1'b1, 16'd2);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        tick(3);

        // Zero-byte PRG load: patch only, value = PRG_CPU_BASE
        start_load(5'd1);
        finish_load(1'b1, 16'd0);
        chk("zero_overflow_clear", {31'd0, overflow}, 32'd0);
        tick(3);

        // Reset after the first pointer byte: nothing further written
        start_load(5'd1);
        e.a = PTR_ADDR;
        e.d = 8'h95;
        exp_q.push_back(e);
        ws0 = writes_seen;
        bus.dio_downloading = 1'b0;
        n = 0;
        while (writes_seen < ws0 + 1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("first_ptr_seen", writes_seen - ws0, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1);
        chk("abort_wr", {31'd0, bus.wr}, 32'd0);
        chk("abort_downloading", {31'd0, downloading}, 32'd0);
        chk("abort_overflow", {31'd0, overflow}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(12);
        chk("abort_no_more_writes", writes_seen - ws0, 32'd1);
        chk("abort_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end
endmodule
